module_rca_seq_alu: RTL and testbench

- Sequential add/subtract unit that drives operands into an internal instance of the 8-bit ripple-carry adder and captures its result. Results are returned through a valid/ready handshake.
- Subtraction reuses the carry-less adder in two passes: a + ~b, then +1.
- Gives the rest of the design a registered, flow-controlled front end to the combinational adder, with a programmable ripple settle time.

---
 rtl/rca_seq_pkg.sv | 5 +
 rtl/module_rca_8bits.sv | 16 +
 rtl/module_rca_seq_alu.sv | 96 +++++++++
 tb/tb_module_rca_seq_alu.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/rca_seq_pkg.sv
// rca_seq_pkg: shared state type and default settle time for the sequential adder front end
package rca_seq_pkg;
    typedef enum logic [1:0] {IDLE, PASS1, PASS2, DONE} state_t;
    localparam int DEFAULT_SETTLE = 2;
endpackage

// File: rtl/module_rca_8bits.sv
// module_rca_8bits: carry-less ripple-carry adder, sum[WIDTH] is the carry out
module module_rca_8bits #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH:0]   sum
);
    logic [WIDTH:0] c;
    assign c[0] = 1'b0;
    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    assign sum[WIDTH] = c[WIDTH];
endmodule

// File: rtl/module_rca_seq_alu.sv
// module_rca_seq_alu: registered valid/ready add/subtract front end around the ripple-carry adder
module module_rca_seq_alu
    import rca_seq_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int SETTLE_CYCLES = DEFAULT_SETTLE
) (
    input  logic             clk_pi,
    input  logic             rst_n_pi,
    input  logic             in_valid_pi,
    output logic             in_ready_po,
    input  logic [WIDTH-1:0] op_a_pi,
    input  logic [WIDTH-1:0] op_b_pi,
    input  logic             sub_pi,
    output logic             out_valid_po,
    input  logic             out_ready_pi,
    output logic [WIDTH:0]   result_po
);
    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(SETTLE_CYCLES - 1);

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [WIDTH-1:0] a_q, b_q;
    logic           sub_q, c1;
    logic [WIDTH:0] sum;

    module_rca_8bits #(.WIDTH(WIDTH)) u_rca (
        .a   (a_q),
        .b   (b_q),
        .sum (sum)
    );

    // Handshake, settle counting and two-pass subtract (a + ~b, then +1) sequencing
    always_ff @(posedge clk_pi or negedge rst_n_pi) begin
        if (!rst_n_pi) begin
            state        <= IDLE;
            cnt          <= '0;
            a_q          <= '0;
            b_q          <= '0;
            sub_q        <= 1'b0;
            c1           <= 1'b0;
            in_ready_po  <= 1'b0;
            out_valid_po <= 1'b0;
            result_po    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready_po <= 1'b1;
                    if (in_valid_pi && in_ready_po) begin
                        a_q         <= op_a_pi;
                        b_q         <= sub_pi ? ~op_b_pi : op_b_pi;
                        sub_q       <= sub_pi;
                        cnt         <= '0;
                        in_ready_po <= 1'b0;
                        state       <= PASS1;
                    end
                end
                PASS1: begin
                    if (cnt == LAST) begin
                        if (sub_q) begin
                            c1    <= sum[WIDTH];
                            a_q   <= sum[WIDTH-1:0];
                            b_q   <= WIDTH'(1);
                            cnt   <= '0;
                            state <= PASS2;
                        end else begin
                            result_po    <= sum;
                            out_valid_po <= 1'b1;
                            state        <= DONE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PASS2: begin
                    if (cnt == LAST) begin
                        result_po    <= {c1 | sum[WIDTH], sum[WIDTH-1:0]};
                        out_valid_po <= 1'b1;
                        state        <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready_pi) begin
                        out_valid_po <= 1'b0;
                        in_ready_po  <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_module_rca_seq_alu.sv
// tb_module_rca_seq_alu: directed vectors checked against an arithmetic model and literal expectations
module tb_module_rca_seq_alu;
    localparam int S = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] op_a = '0;
    logic [7:0] op_b = '0;
    logic       sub = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [8:0] result;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_acc = 0;
    logic [8:0] exp_q[$];

    module_rca_seq_alu #(.WIDTH(8), .SETTLE_CYCLES(S)) dut (
        .clk_pi       (clk),
        .rst_n_pi     (rst_n),
        .in_valid_pi  (in_valid),
        .in_ready_po  (in_ready),
        .op_a_pi      (op_a),
        .op_b_pi      (op_b),
        .sub_pi       (sub),
        .out_valid_po (out_valid),
        .out_ready_pi (out_ready),
        .result_po    (result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b, input logic s);
        logic [7:0] d;
        d = a - b;
        return s ? {(a >= b) ? 1'b1 : 1'b0, d} : {1'b0, a} + {1'b0, b};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at cycle %0d", name, got, exp, cyc);
        end
    endtask

    // Every cycle a result is presented it must equal the model's oldest outstanding answer
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) chk("unexpected_out_valid", 32'(out_valid), 32'd0);
            else chk("model_result", 32'(result), 32'(exp_q[0]));
        end
    end

    always @(posedge clk) begin
        if (rst_n && out_valid && out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
    end

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic s,
                          input logic [8:0] lit, input int stall, input int gap);
        int n, t0;
        chk("model_pin", 32'(model(a, b, s)), 32'(lit));
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("in_ready_before_accept", 32'(in_ready), 32'd1);
        out_ready = (stall == 0);
        in_valid = 1'b1; op_a = a; op_b = b; sub = s;
        @(posedge clk); #1;
        t0 = cyc;
        if (gap > 0) chk("accept_spacing", 32'(t0 - last_acc), 32'(gap));
        last_acc = t0;
        exp_q.push_back(model(a, b, s));
        in_valid = 1'b0; op_a = 8'($urandom); op_b = 8'($urandom); sub = 1'($urandom);
        chk("in_ready_after_accept", 32'(in_ready), 32'd0);
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk("out_valid_seen", 32'(out_valid), 32'd1);
        chk("latency", 32'(cyc - t0), 32'(s ? 2 * S : S));
        chk("result_lit", 32'(result), 32'(lit));
        for (int i = 0; i < stall; i++) begin
            in_valid = ~in_valid; op_a = 8'($urandom); op_b = 8'($urandom);
            @(posedge clk); #1;
            chk("stall_result", 32'(result), 32'(lit));
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("out_valid_cleared", 32'(out_valid), 32'd0);
        chk("in_ready_restored", 32'(in_ready), 32'd1);
    endtask

    initial begin
        #12;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_result", 32'(result), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("in_ready_after_release", 32'(in_ready), 32'd1);

        run_op(8'hFF, 8'hFF, 1'b0, 9'h1FE, 0, 0);
        run_op(8'h05, 8'h03, 1'b1, 9'h102, 0, 0);
        run_op(8'h03, 8'h05, 1'b1, 9'h0FE, 0, 0);
        run_op(8'h00, 8'h00, 1'b1, 9'h100, 0, 0);
        run_op(8'h80, 8'h7F, 1'b1, 9'h101, 0, 0);
        run_op(8'h01, 8'h01, 1'b0, 9'h002, 5, 0);

        // Reset while a subtract sits in its second pass
        in_valid = 1'b1; op_a = 8'h05; op_b = 8'h03; sub = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (S + 1) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("midreset_out_valid", 32'(out_valid), 32'd0);
        chk("midreset_in_ready", 32'(in_ready), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("held_reset_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("in_ready_after_midreset", 32'(in_ready), 32'd1);
        run_op(8'h10, 8'h20, 1'b0, 9'h030, 0, 0);

        for (int k = 0; k < 10; k++) run_op(8'hFF, 8'hFF, 1'b0, 9'h1FE, 0, (k == 0) ? 0 : S + 2);

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
